spi_frame_ctrl: RTL and testbench

Command sequencer between the UART byte front end and the SPI byte-exchange engine of the serial-to-SPI bridge. It parses a one-byte header from the host stream and sequences framed SPI transfers with chip-select. It also controls the target reset line and returns response, ack and status bytes to the UART transmitter. There is no data buffering: each byte is fully round-tripped before the next is consumed.

---
 rtl/spi_frame_ctrl_pkg.sv | 22 ++
 rtl/spi_frame_ctrl_if.sv | 28 ++
 rtl/spi_frame_ctrl_cycle_timer.sv | 31 +++
 rtl/spi_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_ctrl_pkg.sv
// Shared constants and state encoding for the serial-to-SPI bridge command sequencer.
package serial2spi_pkg;

  localparam logic [1:0] OP_XFER   = 2'b00;
  localparam logic [1:0] OP_SETRST = 2'b01;
  localparam logic [1:0] OP_PULSE  = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_X_WAIT  = 3'd1,
    S_X_START = 3'd2,
    S_X_BUSY  = 3'd3,
    S_X_REPLY = 3'd4,
    S_PULSE   = 3'd5,
    S_REPLY   = 3'd6
  } state_e;

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Host byte stream, reply stream, SPI engine and target control signals of the sequencer.
interface spi_frame_ctrl_if;
  // rx/tx streams: a byte moves on a rising clk edge where valid & ready are both 1;
  // valid never waits for ready, and data is held stable while valid is high.
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       spi_start;
  logic [7:0] spi_wdata;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_rdata;
  logic       cs_n;
  logic       target_rst_n;

  modport master (
    input  rx_valid, rx_data, tx_ready, spi_busy, spi_done, spi_rdata,
    output rx_ready, tx_valid, tx_data, spi_start, spi_wdata, cs_n, target_rst_n
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, spi_busy, spi_done, spi_rdata,
    input  rx_ready, tx_valid, tx_data, spi_start, spi_wdata, cs_n, target_rst_n
  );
endinterface

// File: rtl/spi_frame_ctrl_cycle_timer.sv
// Loadable down-counter that saturates at zero; shared by the receive timeout and the reset pulse.
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_frame_ctrl.sv
// Header-driven sequencer: framed SPI transfers under chip-select, target reset control, status.
module spi_frame_ctrl
  import serial2spi_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         PULSE_CYCLES   = 1000,
  parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0] ERR_BYTE       = ERR_BYTE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  spi_frame_ctrl_if.master        bus,
  output state_e                  dbg_state_o
);

  localparam int MAXC = (TIMEOUT_CYCLES > PULSE_CYCLES) ? TIMEOUT_CYCLES : PULSE_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  // The timer is loaded with N-1 and the zero cycle is the last one, giving exactly N cycles.
  localparam logic [TW-1:0] TO_LOAD    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);

  state_e     state_q, state_d;
  logic       cs_n_q, cs_n_d;
  logic       trst_n_q, trst_n_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] wdata_q, wdata_d;
  logic [6:0] rem_q, rem_d;
  logic [5:0] err_cnt_q, err_cnt_d;

  logic          timer_load, timer_en, timer_zero;
  logic [TW-1:0] timer_val;

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (timer_en),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cs_n_q    <= 1'b1;
      trst_n_q  <= 1'b1;
      tx_data_q <= 8'h00;
      wdata_q   <= 8'h00;
      rem_q     <= 7'd0;
      err_cnt_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      trst_n_q  <= trst_n_d;
      tx_data_q <= tx_data_d;
      wdata_q   <= wdata_d;
      rem_q     <= rem_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    trst_n_d   = trst_n_q;
    tx_data_d  = tx_data_q;
    wdata_d    = wdata_q;
    rem_d      = rem_q;
    err_cnt_d  = err_cnt_q;
    timer_load = 1'b0;
    timer_val  = TO_LOAD;
    timer_en   = (state_q == S_X_WAIT) || (state_q == S_PULSE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          unique case (bus.rx_data[7:6])
            OP_XFER: begin
              cs_n_d     = 1'b0;
              rem_d      = 7'(bus.rx_data[5:0]) + 7'd1;
              timer_load = 1'b1;
              state_d    = S_X_WAIT;
            end
            OP_SETRST: begin
              trst_n_d  = bus.rx_data[0];
              tx_data_d = ACK_BYTE;
              state_d   = S_REPLY;
            end
            OP_PULSE: begin
              trst_n_d   = 1'b0;
              timer_load = 1'b1;
              timer_val  = PULSE_LOAD;
              state_d    = S_PULSE;
            end
            OP_STATUS: begin
              tx_data_d = {2'b00, err_cnt_q};
              state_d   = S_REPLY;
            end
          endcase
        end
      end
      S_X_WAIT: begin
        // A byte arriving in the expiry cycle takes priority over the abort.
        if (bus.rx_valid) begin
          wdata_d = bus.rx_data;
          state_d = S_X_START;
        end else if (timer_zero) begin
          cs_n_d    = 1'b1;
          err_cnt_d = (err_cnt_q == 6'h3F) ? err_cnt_q : err_cnt_q + 6'd1;
          tx_data_d = ERR_BYTE;
          state_d   = S_REPLY;
        end
      end
      S_X_START: if (!bus.spi_busy) state_d = S_X_BUSY;
      S_X_BUSY: begin
        if (bus.spi_done) begin
          tx_data_d = bus.spi_rdata;
          state_d   = S_X_REPLY;
        end
      end
      S_X_REPLY: begin
        if (bus.tx_ready) begin
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            cs_n_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_load = 1'b1;
            state_d    = S_X_WAIT;
          end
        end
      end
      S_PULSE: begin
        if (timer_zero) begin
          trst_n_d  = 1'b1;
          tx_data_d = ACK_BYTE;
          state_d   = S_REPLY;
        end
      end
      S_REPLY: if (bus.tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rx_ready     = (state_q == S_IDLE) || (state_q == S_X_WAIT);
    bus.tx_valid     = (state_q == S_REPLY) || (state_q == S_X_REPLY);
    bus.spi_start    = (state_q == S_X_START) && !bus.spi_busy;
    bus.tx_data      = tx_data_q;
    bus.spi_wdata    = wdata_q;
    bus.cs_n         = cs_n_q;
    bus.target_rst_n = trst_n_q;
    dbg_state_o      = state_q;
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl with an inverting SPI engine model behind the interface.
module tb_spi_frame_ctrl;
  import serial2spi_pkg::*;

  localparam int TO = 20;
  localparam int PC = 5;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_frame_ctrl_if bus();
  state_e dbg_state;

  spi_frame_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .PULSE_CYCLES   (PC),
    .ACK_BYTE       (8'hA5),
    .ERR_BYTE       (8'hEE)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // SPI engine model: notices a start pulse, goes busy, returns wdata^FF after spi_lat cycles
  logic       m_busy = 1'b0, m_done = 1'b0, m_pend = 1'b0, stale_done = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  int         m_cnt = 0, spi_lat = 2, start_cnt = 0;

  assign bus.spi_busy  = m_busy;
  assign bus.spi_done  = m_done | stale_done;
  assign bus.spi_rdata = m_rdata;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_pend = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pend) begin
        m_pend = 1'b0; m_busy = 1'b1; m_cnt = spi_lat;
      end else if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          m_rdata = bus.spi_wdata ^ 8'hFF;
        end
      end
      if (bus.spi_start === 1'b1) begin
        start_cnt++;
        m_pend = 1'b1;
      end
    end
  end

  // scoreboard
  int n_asserts = 0;
  int n_fail    = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: both are entered and left just after a falling edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("rx_accept_wait", 32'(n < 1000), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic get_reply(input string tag);
    int n = 0;
    logic [7:0] exp_b;
    bus.tx_ready = 1'b1;
    while (bus.tx_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("tx_valid_wait", 32'(n < 1000), 32'd1);
    exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    chk(tag, 32'(bus.tx_data), 32'(exp_b));
    @(negedge clk);
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    int n, bad, s0;
    logic [7:0] hdr3_data[4];
    logic [7:0] hdr3_exp[4];
    hdr3_data = '{8'hAC, 8'h53, 8'h00, 8'h00};
    hdr3_exp  = '{8'h53, 8'hAC, 8'hFF, 8'hFF};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;

    // reset values appear without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs_n", 32'(bus.cs_n), 32'd1);
    chk("rst_target_rst_n", 32'(bus.target_rst_n), 32'd1);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_spi_wdata", 32'(bus.spi_wdata), 32'd0);
    chk("rst_spi_start", 32'(bus.spi_start), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("idle_state", 32'(dbg_state), 32'(S_IDLE));

    // 4-byte XFER, engine returns inverted bytes
    s0 = start_cnt;
    send_byte(8'h03);
    chk("xfer4_cs_low", 32'(bus.cs_n), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_byte(hdr3_data[i]);
      if (i == 0) chk("xfer4_x_start", 32'(dbg_state), 32'(S_X_START));
      exp_q.push_back(hdr3_exp[i]);
      get_reply("xfer4_reply");
      chk("xfer4_cs", 32'(bus.cs_n), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("xfer4_starts", 32'(start_cnt - s0), 32'd4);
    chk("xfer4_idle", 32'(dbg_state), 32'(S_IDLE));

    // timeout after one byte of a 2-byte frame, then STATUS reports one error
    send_byte(8'h01);
    send_byte(8'h5A);
    exp_q.push_back(8'hA5);
    get_reply("to_first_reply");
    n = 0;
    bad = 0;
    while (bus.tx_valid !== 1'b1 && n < 100) begin
      if (bus.rx_ready !== 1'b1 || bus.cs_n !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_wait_signals", 32'(bad), 32'd0);
    chk("to_cs_high", 32'(bus.cs_n), 32'd1);
    exp_q.push_back(8'hEE);
    get_reply("to_err_byte");
    send_byte(8'hC0);
    exp_q.push_back(8'h01);
    get_reply("status_err_cnt");

    // target reset pulse: low for exactly PC cycles, then ACK
    send_byte(8'h80);
    n = 0;
    while (bus.target_rst_n !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    chk("pulse_low_cycles", 32'(n), 32'(PC));
    chk("pulse_ack_valid", 32'(bus.tx_valid), 32'd1);
    exp_q.push_back(8'hA5);
    get_reply("pulse_ack");

    // SET_RESET low then high
    send_byte(8'h40);
    chk("setrst_low", 32'(bus.target_rst_n), 32'd0);
    exp_q.push_back(8'hA5);
    get_reply("setrst0_ack");
    send_byte(8'h41);
    chk("setrst_high", 32'(bus.target_rst_n), 32'd1);
    exp_q.push_back(8'hA5);
    get_reply("setrst1_ack");

    // reply backpressure well beyond the receive timeout
    send_byte(8'h01);
    send_byte(8'h3C);
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("bp_reply_wait", 32'(n < 100), 32'd1);
    s0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rx_ready !== 1'b0 || bus.tx_valid !== 1'b1 || bus.cs_n !== 1'b0) bad++;
    end
    chk("bp_hold_signals", 32'(bad), 32'd0);
    chk("bp_no_start", 32'(start_cnt - s0), 32'd0);
    exp_q.push_back(8'hC3);
    get_reply("bp_reply0");
    chk("bp_cs_mid", 32'(bus.cs_n), 32'd0);
    send_byte(8'h0F);
    exp_q.push_back(8'hF0);
    get_reply("bp_reply1");
    chk("bp_cs_end", 32'(bus.cs_n), 32'd1);

    // reset while the engine is mid-exchange
    spi_lat = 10;
    send_byte(8'h00);
    send_byte(8'h77);
    repeat (3) @(negedge clk);
    chk("rst_mid_state", 32'(dbg_state), 32'(S_X_BUSY));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", 32'(bus.cs_n), 32'd1);
    chk("rst_mid_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_mid_spi_start", 32'(bus.spi_start), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spi_lat = 2;
    @(negedge clk);
    chk("post_rst_state", 32'(dbg_state), 32'(S_IDLE));
    stale_done = 1'b1;
    @(negedge clk);
    stale_done = 1'b0;
    @(negedge clk);
    chk("stale_done_state", 32'(dbg_state), 32'(S_IDLE));
    chk("stale_done_tx_valid", 32'(bus.tx_valid), 32'd0);
    send_byte(8'h00);
    send_byte(8'h12);
    exp_q.push_back(8'hED);
    get_reply("post_rst_xfer");
    chk("post_rst_cs", 32'(bus.cs_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
